sramlike_mem_responder: RTL and testbench

// - Responder (slave) end of the SRAM-like data interface (req/wr/size/addr/wdata/wstrb -> addr_ok/data_ok/rdata)

---
 rtl/sramlike_pkg.sv | 18 +
 rtl/sramlike_resp_fifo.sv | 95 +++++++++
 rtl/sramlike_mem_responder.sv | 100 ++++++++++
 tb/tb_sramlike_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sramlike_pkg.sv
// Shared types and constants for the SRAM-like data interface.
package sramlike_pkg;

    // Transfer size encodings carried on data_size (byte, halfword, word).
    localparam logic [1:0] SRAMLIKE_SIZE_B = 2'd0;
    localparam logic [1:0] SRAMLIKE_SIZE_H = 2'd1;
    localparam logic [1:0] SRAMLIKE_SIZE_W = 2'd2;

    // One request as presented by the initiator in a single cycle.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } sramlike_req_t;

endpackage

// File: rtl/sramlike_resp_fifo.sv
// In-order response queue for the SRAM-like responder.
// Each entry holds {is_read, rdata, age}; age counts cycles since push and
// saturates at LATENCY, so an entry is ready once age reaches LATENCY-1.
// Read data arrives one cycle after the push (sync RAM) and is captured then;
// until captured, the head output forwards it straight from the RAM register.
module sramlike_resp_fifo
    import sramlike_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     push_is_read_i,
    input  logic [31:0]              cap_data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     head_ready_o,
    output logic                     head_is_read_o,
    output logic [31:0]              head_rdata_o
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [3:0] AGE_MAX = 4'(LATENCY);
    localparam logic [3:0] AGE_RDY = 4'(LATENCY - 1);

    logic [PW:0]       head_q, head_d;
    logic [PW:0]       tail_q, tail_d;
    logic [DEPTH-1:0]  is_read_q;
    logic [31:0]       rdata_q [DEPTH];
    logic [3:0]        age_q   [DEPTH];
    logic              cap_pend_q;
    logic [PW-1:0]     cap_idx_q;

    logic [PW-1:0]     head_idx;
    logic [PW-1:0]     tail_idx;

    assign head_idx = head_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];

    // Pointer advance; the extra wrap bit distinguishes full from empty.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (pop_i) begin
            head_d = head_q + 1'b1;
        end
        if (push_i) begin
            tail_d = tail_q + 1'b1;
        end
    end

    // Queue state: pointers, per-entry ages, read-data capture one cycle after push.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            cap_pend_q <= 1'b0;
            cap_idx_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (age_q[i] != AGE_MAX) begin
                    age_q[i] <= age_q[i] + 4'd1;
                end
            end
            if (push_i) begin
                age_q[tail_idx]     <= '0;
                is_read_q[tail_idx] <= push_is_read_i;
            end
            cap_pend_q <= push_i & push_is_read_i;
            cap_idx_q  <= tail_idx;
            if (cap_pend_q) begin
                rdata_q[cap_idx_q] <= cap_data_i;
            end
        end
    end

    assign empty_o        = (head_q == tail_q);
    assign full_o         = (head_q[PW] != tail_q[PW]) && (head_idx == tail_idx);
    assign count_o        = tail_q - head_q;
    assign head_ready_o   = (age_q[head_idx] >= AGE_RDY);
    assign head_is_read_o = is_read_q[head_idx];
    // Only the entry pushed last cycle can be uncaptured, so a slot match means it is the head.
    assign head_rdata_o   = (cap_pend_q && (cap_idx_q == head_idx)) ? cap_data_i
                                                                    : rdata_q[head_idx];

endmodule

// File: rtl/sramlike_mem_responder.sv
// Responder end of the SRAM-like data interface backed by an on-chip word RAM.
// Requests are accepted while fewer than OUTSTANDING responses are pending and
// answered strictly in order, each no earlier than LATENCY cycles after accept.
module sramlike_mem_responder
    import sramlike_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int OUTSTANDING = 4,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    input  logic        addr_stall,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        busy
);

    localparam int CW = $clog2(OUTSTANDING) + 1;

    sramlike_req_t     req;
    logic [ADDR_W-1:0] word_idx;
    logic              accept;
    logic              retire;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              head_ready;
    logic              head_is_read;
    logic [31:0]       head_rdata;

    logic [31:0]       ram_q [2**ADDR_W];
    logic [31:0]       ram_rdata_q;

    // Size is informational and only the word-index address bits select a RAM word.
    logic              unused_bits;

    assign req = '{wr:    data_wr,
                   size:  data_size,
                   addr:  data_addr,
                   wdata: data_wdata,
                   wstrb: data_wstrb};

    assign word_idx    = req.addr[ADDR_W+1:2];
    assign unused_bits = ^{req.size, req.addr[31:ADDR_W+2], req.addr[1:0],
                           (req.size == SRAMLIKE_SIZE_B),
                           (req.size == SRAMLIKE_SIZE_H),
                           (req.size == SRAMLIKE_SIZE_W)};

    // Slot check uses the registered count only, so a same-cycle retire never frees a slot.
    // Both handshakes are held low while reset is asserted so nothing is written or answered.
    assign accept = data_req & ~addr_stall & ~fifo_full & ~rst;
    assign retire = ~fifo_empty & head_ready & ~rst;

    // Word RAM: byte-enabled write and synchronous read, both on the accept edge; no reset.
    always_ff @(posedge clk) begin
        if (accept && req.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (req.wstrb[b]) begin
                    ram_q[word_idx][8*b +: 8] <= req.wdata[8*b +: 8];
                end
            end
        end
        if (accept && !req.wr) begin
            ram_rdata_q <= ram_q[word_idx];
        end
    end

    sramlike_resp_fifo #(
        .DEPTH   (OUTSTANDING),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push_i         (accept),
        .push_is_read_i (~req.wr),
        .cap_data_i     (ram_rdata_q),
        .pop_i          (retire),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .count_o        (fifo_count),
        .head_ready_o   (head_ready),
        .head_is_read_o (head_is_read),
        .head_rdata_o   (head_rdata)
    );

    assign data_addr_ok = accept;
    assign data_data_ok = retire;
    assign data_rdata   = (retire && head_is_read) ? head_rdata : 32'h0;
    assign busy         = (fifo_count != '0);

endmodule

// File: tb/tb_sramlike_mem_responder.sv
// Bench for sramlike_mem_responder: three instances (LATENCY 2, 8, 1) share one
// randomized stimulus stream; a timestamp-queue model predicts every output.
module tb_sramlike_mem_responder;
    import sramlike_pkg::*;

    localparam int NI   = 3;
    localparam int OUTS = 4;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        stall;

    logic [31:0] rdata_w [NI];
    logic        aok_w   [NI];
    logic        dok_w   [NI];
    logic        busy_w  [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sramlike_mem_responder #(
            .ADDR_W      (10),
            .OUTSTANDING (OUTS),
            .LATENCY     (lat_of(g))
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .data_req     (req),
            .data_wr      (wr),
            .data_size    (size),
            .data_addr    (addr),
            .data_wdata   (wdata),
            .data_wstrb   (wstrb),
            .addr_stall   (stall),
            .data_rdata   (rdata_w[g]),
            .data_addr_ok (aok_w[g]),
            .data_data_ok (dok_w[g]),
            .busy         (busy_w[g])
        );
    end

    typedef struct {
        int          t;
        bit          rd;
        logic [31:0] d;
    } pend_t;

    pend_t       pq      [NI][$];
    logic [31:0] mdl_mem [NI][64];
    logic [31:0] last_rd [NI];
    int          aok_cnt [NI];
    int          dok_cnt [NI];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mdl_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a request accepted in cycle t completes in the first cycle
    // >= t+LATENCY in which it is the oldest pending one.
    always @(negedge clk) begin : mdl
        int          sz;
        bit          e_aok;
        bit          e_dok;
        logic [31:0] e_rd;
        logic [5:0]  wi;
        logic [31:0] m;
        pend_t       h;
        pend_t       n;
        if (mdl_en) begin
            for (int k = 0; k < NI; k++) begin
                sz    = pq[k].size();
                e_aok = !rst && req && !stall && (sz < OUTS);
                e_dok = 1'b0;
                e_rd  = 32'h0;
                if (!rst && sz > 0) begin
                    h = pq[k][0];
                    if (cyc >= h.t + lat_of(k)) begin
                        e_dok = 1'b1;
                        if (h.rd) e_rd = h.d;
                    end
                end
                chk($sformatf("i%0d addr_ok c%0d", k, cyc), 32'(aok_w[k]), 32'(e_aok));
                chk($sformatf("i%0d data_ok c%0d", k, cyc), 32'(dok_w[k]), 32'(e_dok));
                chk($sformatf("i%0d rdata c%0d", k, cyc), rdata_w[k], e_rd);
                chk($sformatf("i%0d busy c%0d", k, cyc), 32'(busy_w[k]), 32'(sz != 0));
                if (aok_w[k]) aok_cnt[k]++;
                if (dok_w[k]) begin
                    dok_cnt[k]++;
                    last_rd[k] = rdata_w[k];
                end
                if (rst) begin
                    pq[k].delete();
                end else begin
                    if (e_dok) void'(pq[k].pop_front());
                    if (e_aok) begin
                        wi = addr[7:2];
                        m  = mdl_mem[k][wi];
                        n.t = cyc;
                        if (wr) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wstrb[b]) m[8*b +: 8] = wdata[8*b +: 8];
                            end
                            mdl_mem[k][wi] = m;
                            n.rd = 1'b0;
                            n.d  = 32'h0;
                        end else begin
                            n.rd = 1'b1;
                            n.d  = m;
                        end
                        pq[k].push_back(n);
                    end
                end
            end
        end
    end

    // Byte address of word idx (0..63) with random ignored bits above and below.
    function automatic logic [31:0] rnd_addr(input int idx);
        logic [31:0] r;
        logic [5:0]  w;
        r = $urandom;
        w = 6'(idx);
        return {r[31:12], 4'b0000, w, r[1:0]};
    endfunction

    task automatic drive(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input bit st);
        req   = r;
        wr    = w;
        addr  = a;
        wdata = d;
        wstrb = s;
        stall = st;
        size  = SRAMLIKE_SIZE_W;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 1'b0);
    endtask

    initial begin
        int a0;
        int d0;
        rst   = 1'b1;
        req   = 1'b0;
        wr    = 1'b0;
        size  = 2'd0;
        addr  = 32'h0;
        wdata = 32'h0;
        wstrb = 4'h0;
        stall = 1'b0;
        for (int k = 0; k < NI; k++) begin
            aok_cnt[k] = 0;
            dok_cnt[k] = 0;
            last_rd[k] = 32'h0;
        end
        @(posedge clk);
        #1;
        mdl_en = 1'b1;
        idle(2);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("i%0d reset busy", k), 32'(busy_w[k]), 32'h0);
            chk($sformatf("i%0d reset data_ok", k), 32'(dok_w[k]), 32'h0);
        end
        rst = 1'b0;

        // Preload the 64 words the bench uses.
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b1, rnd_addr(i), $urandom, 4'hF, 1'b0);
            idle(2);
        end

        // Write then read of 0x40.
        drive(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        idle(12);
        for (int k = 0; k < NI; k++) chk($sformatf("i%0d wr_rd 0x40", k), last_rd[k], 32'hDEADBEEF);

        // Byte strobes on 0x80.
        drive(1'b1, 1'b1, 32'h80, 32'h11223344, 4'hF, 1'b0);
        drive(1'b1, 1'b1, 32'h80, 32'hAABBCCDD, 4'b0101, 1'b0);
        drive(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0);
        idle(12);
        for (int k = 0; k < NI; k++) chk($sformatf("i%0d wstrb 0x80", k), last_rd[k], 32'h11BB33DD);

        // Read immediately after write to the same word.
        drive(1'b1, 1'b1, 32'h10, 32'h00000055, 4'hF, 1'b0);
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        idle(12);
        for (int k = 0; k < NI; k++) chk($sformatf("i%0d raw 0x10", k), last_rd[k], 32'h00000055);

        // Full queue on the LATENCY=8 instance.
        a0 = aok_cnt[1];
        repeat (9) drive(1'b1, 1'b0, rnd_addr($urandom_range(0, 63)), $urandom, 4'h0, 1'b0);
        chk("full accepts c0..8", 32'(aok_cnt[1] - a0), 32'd4);
        chk("full busy", 32'(busy_w[1]), 32'h1);
        drive(1'b1, 1'b0, rnd_addr($urandom_range(0, 63)), $urandom, 4'h0, 1'b0);
        chk("full accepts c9", 32'(aok_cnt[1] - a0), 32'd5);
        repeat (10) drive(1'b1, 1'b0, rnd_addr($urandom_range(0, 63)), $urandom, 4'h0, 1'b0);
        idle(14);

        // Streaming reads on the LATENCY=1 instance.
        d0 = dok_cnt[2];
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, rnd_addr(i), $urandom, 4'h0, 1'b0);
        idle(12);
        chk("stream data_ok count", 32'(dok_cnt[2] - d0), 32'd16);

        // Reset with responses pending; RAM contents survive.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rnd_addr(40 + i), 32'h0, 4'h0, 1'b0);
        d0  = dok_cnt[1];
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0);
        rst = 1'b0;
        idle(10);
        chk("reset drops data_ok", 32'(dok_cnt[1] - d0), 32'd0);
        chk("reset busy", 32'(busy_w[1]), 32'h0);
        drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        idle(12);
        chk("ram kept over reset", last_rd[1], 32'hDEADBEEF);

        // Alternating stall with request held high.
        a0 = aok_cnt[0];
        for (int i = 0; i < 20; i++)
            drive(1'b1, 1'($urandom_range(0, 1)), rnd_addr($urandom_range(0, 63)),
                  $urandom, 4'($urandom), 1'(i % 2));
        idle(12);
        chk("stall accepts", 32'(aok_cnt[0] - a0), 32'd10);

        // Random traffic with occasional reset.
        repeat (1500) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  rnd_addr($urandom_range(0, 63)), $urandom, 4'($urandom),
                  ($urandom_range(0, 4) == 0));
        end
        rst = 1'b0;
        idle(15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
